// File: rtl/rec_fn_wb_pkg.sv
// ---------------------------------------------------------------------------
// rec_fn_wb_pkg
// Shared constants and types for the recoded-single writeback stage.
//   FLAG_W / FLAG_*  : exception flag width and bit positions (NV,DZ,OF,UF,NX)
//   REC_W / OUT_W    : recoded single width (33) and IEEE binary32 width (32)
//   BIAS_ADJ         : recoded exponent minus this gives the IEEE biased exponent
//   MIN_NORM_EXP     : smallest recoded exponent that is an IEEE normal
//   CANON_NAN_32     : canonical quiet NaN used when canonicalisation is built in
//   wb_entry_t       : one FIFO entry {ieee result, flags}
// ---------------------------------------------------------------------------
package rec_fn_wb_pkg;

    localparam int FLAG_W  = 5;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int REC_W = 33;
    localparam int OUT_W = 32;

    localparam logic [7:0]  BIAS_ADJ     = 8'd129;
    localparam logic [8:0]  MIN_NORM_EXP = 9'd130;
    localparam logic [31:0] CANON_NAN_32 = 32'h7FC0_0000;

    typedef struct packed {
        logic [OUT_W-1:0]  bits;
        logic [FLAG_W-1:0] flags;
    } wb_entry_t;

endpackage

// File: rtl/rec_fn_to_fn_wb_stage_conv.sv
// ---------------------------------------------------------------------------
// rec_fn_to_fn_32
// Purely combinational converter from 33-bit recoded single to IEEE binary32.
//   rec_i  [32:0] : recoded value {sign, exp[8:0], fract[22:0]}
//   ieee_o [31:0] : IEEE binary32 value
// Build option: REC_FN_WB_NAN_CANON_EN -- when defined every NaN is emitted
// as the canonical quiet NaN (sign and payload dropped); when undefined NaN
// sign and fraction pass through unchanged.
// ---------------------------------------------------------------------------
import rec_fn_wb_pkg::*;

module rec_fn_to_fn_32 (
    input  logic [REC_W-1:0] rec_i,
    output logic [OUT_W-1:0] ieee_o
);

    logic        sign;
    logic [8:0]  exp_in;
    logic [22:0] fract;
    logic        is_zero;
    logic        is_special;
    logic        is_nan;
    logic        is_inf;
    logic        is_sub;
    logic [24:0] sig;
    logic [4:0]  shift;
    logic [22:0] denorm_fract;
    logic [7:0]  exp_adj;
    logic [7:0]  exp_out;
    logic [22:0] fract_out;

    assign sign   = rec_i[32];
    assign exp_in = rec_i[31:23];
    assign fract  = rec_i[22:0];

    // The top three exponent bits classify the value: 000 zero, 11x special.
    assign is_zero    = (exp_in[8:6] == 3'b000);
    assign is_special = (exp_in[8:7] == 2'b11);
    assign is_nan     = is_special & exp_in[6];
    assign is_inf     = is_special & ~exp_in[6];

    assign sig    = {1'b0, ~is_zero, fract};
    assign is_sub = (exp_in < MIN_NORM_EXP);

    // Subnormal exponents sit at 107..129, so the low five bits alone give
    // the denormalising distance once the 5-bit subtraction wraps.
    assign shift        = 5'd1 - exp_in[4:0];
    assign denorm_fract = 23'((sig >> 1) >> shift);

    assign exp_adj   = exp_in[7:0] - BIAS_ADJ;
    assign exp_out   = (is_sub ? 8'd0 : exp_adj) | {8{is_nan | is_inf}};
    assign fract_out = is_sub ? denorm_fract : (is_inf ? 23'd0 : fract);

`ifdef REC_FN_WB_NAN_CANON_EN
    assign ieee_o = is_nan ? CANON_NAN_32 : {sign, exp_out, fract_out};
`else
    assign ieee_o = {sign, exp_out, fract_out};
`endif

endmodule

// File: rtl/rec_fn_to_fn_wb_stage.sv
// ---------------------------------------------------------------------------
// rec_fn_to_fn_wb_stage
// Writeback stage behind the double->single recoded converter. Converts the
// recoded result to IEEE binary32 and buffers {result, flags} in a 2-entry
// in-order skid FIFO toward the register-file write port, while keeping a
// sticky fflags register for the CSR block.
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready : upstream handshake; in_rec (33b), in_flags (5b)
//   out_valid/out_ready : downstream handshake; out_bits (32b), out_flags (5b)
//   fflags            : sticky OR of flags of every accepted beat
//   fflags_clr        : CSR clear; with a same-cycle accept the new flags stay
// Handshake: a beat moves on a rising edge where valid and ready are both 1.
// in_ready is a flop (count < 2 next cycle), so it has no combinational path
// from in_valid or out_ready. out_bits/out_flags are the head entry and hold
// still while out_valid & ~out_ready.
// Build option: REC_FN_WB_NAN_CANON_EN (see rec_fn_to_fn_32).
// ---------------------------------------------------------------------------
import rec_fn_wb_pkg::*;

module rec_fn_to_fn_wb_stage (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REC_W-1:0]  in_rec,
    input  logic [FLAG_W-1:0] in_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_bits,
    output logic [FLAG_W-1:0] out_flags,
    output logic [FLAG_W-1:0] fflags,
    input  logic              fflags_clr
);

    logic [OUT_W-1:0]  conv_bits;
    wb_entry_t         new_entry;

    // slot0 is always the head; a pop shifts slot1 forward.
    wb_entry_t         slot0_q, slot0_d;
    wb_entry_t         slot1_q, slot1_d;
    logic [1:0]        count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic [FLAG_W-1:0] fflags_q, fflags_d;

    logic              push;
    logic              pop;
    logic [1:0]        wr_idx;

    rec_fn_to_fn_32 u_conv (
        .rec_i  (in_rec),
        .ieee_o (conv_bits)
    );

    assign new_entry = '{bits: conv_bits, flags: in_flags};

    assign push = in_valid & in_ready_q;
    assign pop  = (count_q != 2'd0) & out_ready;

    always_comb begin
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        // Write position is the occupancy left after this cycle's pop.
        wr_idx     = count_q - {1'b0, pop};
        in_ready_d = (count_d != 2'd2);

        if (pop) begin
            slot0_d = slot1_q;
        end
        if (push) begin
            if (wr_idx == 2'd0) begin
                slot0_d = new_entry;
            end else begin
                slot1_d = new_entry;
            end
        end

        // Clear affects only the previously accumulated value.
        fflags_d = (fflags_clr ? '0 : fflags_q) | (push ? in_flags : '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot0_q    <= '0;
            slot1_q    <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            fflags_q   <= '0;
        end else begin
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            fflags_q   <= fflags_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_bits  = slot0_q.bits;
    assign out_flags = slot0_q.flags;
    assign fflags    = fflags_q;

endmodule

// File: tb/tb_rec_fn_to_fn_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_rec_fn_to_fn_wb_stage
// Self-checking bench for rec_fn_to_fn_wb_stage. Inputs change 1 time unit
// after a rising edge; DUT outputs are sampled on the falling edge. Expected
// {bits, flags} are queued when a beat is seen accepted and compared when the
// DUT hands a beat downstream. Random stimulus builds recoded inputs by
// encoding a chosen IEEE value, so the expected result is the chosen value.
// ---------------------------------------------------------------------------
module tb_rec_fn_to_fn_wb_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_rec;
    logic [4:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_bits;
    logic [4:0]  out_flags;
    logic [4:0]  fflags;
    logic        fflags_clr;

    int          n_tests;
    int          n_fail;
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;
    logic [4:0]  exp_ff;
    logic        bp_mode;
    logic [31:0] exp_nan_neg;

    rec_fn_to_fn_wb_stage dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rec     (in_rec),
        .in_flags   (in_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bits   (out_bits),
        .out_flags  (out_flags),
        .fflags     (fflags),
        .fflags_clr (fflags_clr)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", {63'd0, out_valid}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_bits", {32'd0, out_bits}, {32'd0, mon_e[36:5]});
                check("out_flags", {59'd0, out_flags}, {59'd0, mon_e[4:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [32:0] rec, input logic [4:0] fl,
                        input logic [31:0] bits, input logic clr);
        bit done;
        done       = 1'b0;
        in_rec     = rec;
        in_flags   = fl;
        in_valid   = 1'b1;
        fflags_clr = clr;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back({bits, fl});
                exp_ff = (clr ? 5'd0 : exp_ff) | fl;
                done   = 1'b1;
            end
            @(posedge clock);
            #1;
            if (!done && bp_mode) out_ready = ($urandom_range(0, 2) != 0);
        end
        in_valid   = 1'b0;
        fflags_clr = 1'b0;
        if (!done) check("send_timeout", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clock);
            #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Encode a random IEEE value as recoded; returns both forms.
    task automatic gen(output logic [32:0] rec, output logic [31:0] bits);
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        logic [45:0] tmp;
        int          p;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case ($urandom_range(0, 3))
            0: begin
                e    = 8'($urandom_range(1, 254));
                rec  = {s, 9'(e) + 9'd129, f};
                bits = {s, e, f};
            end
            1: begin
                p    = $urandom_range(0, 22);
                f    = (f & ((23'd1 << p) - 23'd1)) | (23'd1 << p);
                tmp  = {23'd0, f} << (23 - p);
                rec  = {s, 9'(p) + 9'd107, tmp[22:0]};
                bits = {s, 8'd0, f};
            end
            2: begin
                rec  = {s, 32'd0};
                bits = {s, 31'd0};
            end
            default: begin
                rec  = {s, 3'b110, 6'($urandom), f};
                bits = {s, 8'hFF, 23'd0};
            end
        endcase
    endtask

    // ---------------- main sequence ----------------
    logic [32:0] r_rec;
    logic [31:0] r_bits;

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_rec     = '0;
        in_flags   = '0;
        out_ready  = 1'b0;
        fflags_clr = 1'b0;
        bp_mode    = 1'b0;
        exp_ff     = '0;
`ifdef REC_FN_WB_NAN_CANON_EN
        exp_nan_neg = 32'h7FC0_0000;
`else
        exp_nan_neg = 32'hFFC0_0001;
`endif

        // Reset state
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_bits", {32'd0, out_bits}, 64'd0);
        check("rst_out_flags", {59'd0, out_flags}, 64'd0);
        check("rst_fflags", {59'd0, fflags}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single transfer, 1-cycle latency
        out_ready = 1'b1;
        send(33'h0_8000_0000, 5'h00, 32'h3F80_0000, 1'b0);
        check("t1_latency", {63'd0, out_valid}, 64'd1);
        idle(2);

        // Specials back-to-back, order preserved
        send(33'h0_0000_0000, 5'h00, 32'h0000_0000, 1'b0);
        send(33'h0_C000_0000, 5'h04, 32'h7F80_0000, 1'b0);
        send(33'h1_C000_0000, 5'h05, 32'hFF80_0000, 1'b0);
        send(33'h0_E040_0000, 5'h10, 32'h7FC0_0000, 1'b0);
        send(33'h1_E040_0001, 5'h10, exp_nan_neg, 1'b0);
        send(33'h0_BFFF_FFFF, 5'h01, 32'h7F7F_FFFF, 1'b0);

        // Subnormals and the smallest normal
        send(33'h0_3F80_0000, 5'h03, 32'h0010_0000, 1'b0);
        send(33'h0_4080_0000, 5'h03, 32'h0040_0000, 1'b0);
        send(33'h0_4100_0000, 5'h00, 32'h0080_0000, 1'b0);
        wait_drain();

        // Backpressure: two accepted, third held off, head stable
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_rec    = 33'h0_8000_0000;
        in_flags  = 5'h01;
        @(negedge clock);
        check("bp_rdy_a", {63'd0, in_ready}, 64'd1);
        exp_q.push_back({32'h3F80_0000, 5'h01});
        @(posedge clock);
        #1;
        in_rec   = 33'h1_8080_0000;
        in_flags = 5'h02;
        @(negedge clock);
        check("bp_rdy_b", {63'd0, in_ready}, 64'd1);
        check("bp_valid_b", {63'd0, out_valid}, 64'd1);
        exp_q.push_back({32'hC000_0000, 5'h02});
        @(posedge clock);
        #1;
        in_rec   = 33'h0_8040_0000;
        in_flags = 5'h04;
        repeat (3) begin
            @(negedge clock);
            check("bp_full", {63'd0, in_ready}, 64'd0);
            check("bp_head", {32'd0, out_bits}, 64'h3F80_0000);
            check("bp_head_flags", {59'd0, out_flags}, 64'h01);
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_rdy_still0", {63'd0, in_ready}, 64'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("bp_rdy_back", {63'd0, in_ready}, 64'd1);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("bp_empty", {63'd0, out_valid}, 64'd0);
        @(posedge clock);
        #1;

        // Sticky flags
        fflags_clr = 1'b1;
        idle(1);
        fflags_clr = 1'b0;
        check("ff_clr0", {59'd0, fflags}, 64'd0);
        exp_ff = 5'd0;
        send(33'h0_8000_0000, 5'h01, 32'h3F80_0000, 1'b0);
        send(33'h0_8000_0000, 5'h10, 32'h3F80_0000, 1'b0);
        check("ff_accum", {59'd0, fflags}, 64'h11);
        send(33'h0_8000_0000, 5'h04, 32'h3F80_0000, 1'b1);
        check("ff_clr_accept", {59'd0, fflags}, 64'h04);
        fflags_clr = 1'b1;
        idle(1);
        fflags_clr = 1'b0;
        check("ff_clr_alone", {59'd0, fflags}, 64'd0);
        exp_ff = 5'd0;
        wait_drain();

        // Random traffic with random backpressure and occasional clears
        bp_mode = 1'b1;
        for (int i = 0; i < 80; i++) begin
            gen(r_rec, r_bits);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) idle(1);
            send(r_rec, 5'($urandom), r_bits, ($urandom_range(0, 7) == 0));
        end
        bp_mode   = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("rand_fflags", {59'd0, fflags}, {59'd0, exp_ff});

        // Reset mid-stream with a full FIFO
        out_ready = 1'b0;
        send(33'h0_8000_0000, 5'h08, 32'h3F80_0000, 1'b0);
        send(33'h1_8080_0000, 5'h02, 32'hC000_0000, 1'b0);
        @(negedge clock);
        check("mid_full", {63'd0, in_ready}, 64'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("mid_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_in_ready", {63'd0, in_ready}, 64'd1);
        check("mid_fflags", {59'd0, fflags}, 64'd0);
        check("mid_out_bits", {32'd0, out_bits}, 64'd0);
        exp_q.delete();
        exp_ff = 5'd0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send(33'h0_C080_0000, 5'h01, 32'h7F80_0000, 1'b0);
        check("post_rst_latency", {63'd0, out_valid}, 64'd1);
        check("post_rst_fflags", {59'd0, fflags}, 64'h01);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
